writeback_regfile: RTL and testbench

- Write-back stage plus architectural register file; consumes the MEM/WB pipeline register outputs directly.
- Selects the write-back value (load data or ALU result), commits it to a 32x32 register file, and serves the two decode-stage read ports.
- Internal write-first bypass lets the decode stage see a same-cycle write-back without an extra forwarding path.
- Keeps a retired-write counter for debug and performance visibility.

---
 rtl/writeback_regfile_pkg.sv | 12 +
 rtl/writeback_regfile_if.sv | 51 +++++
 rtl/writeback_regfile_mux.sv | 13 +
 rtl/writeback_regfile.sv | 83 ++++++++
 tb/tb_writeback_regfile.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/writeback_regfile_pkg.sv
// Shared constants for the write-back stage and register file.
// Also imported by the EX-stage forwarding logic.
package writeback_regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB + decode read-port bundle seen by the write-back register file.
// The master side is the pipeline; the slave side is the register file.
interface writeback_regfile_if
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    logic [DATA_W-1:0] MemReadDataOut;
    logic [DATA_W-1:0] ALUResultOut;
    logic [ADDR_W-1:0] RegRdOut;
    logic              RegWriteOut;
    logic              MemToRegOut;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] WriteData;
    logic [CNT_W-1:0]  WriteCount;

    modport master (
        output MemReadDataOut,
        output ALUResultOut,
        output RegRdOut,
        output RegWriteOut,
        output MemToRegOut,
        output ReadReg1,
        output ReadReg2,
        input  ReadData1,
        input  ReadData2,
        input  WriteData,
        input  WriteCount
    );

    modport slave (
        input  MemReadDataOut,
        input  ALUResultOut,
        input  RegRdOut,
        input  RegWriteOut,
        input  MemToRegOut,
        input  ReadReg1,
        input  ReadReg2,
        output ReadData1,
        output ReadData2,
        output WriteData,
        output WriteCount
    );

endinterface

// File: rtl/writeback_regfile_mux.sv
// 2:1 write-back select; shared with the EX-stage forwarding unit.
module writeback_mux #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    output logic [W-1:0] y
);

    assign y = sel ? a1 : a0;

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage and architectural register file with write-first
// bypass onto the decode read ports and a retired-write counter.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    writeback_regfile_if.slave   wb
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              commit;

    writeback_mux #(.W(DATA_W)) u_mux (
        .sel (wb.MemToRegOut),
        .a0  (wb.ALUResultOut),
        .a1  (wb.MemReadDataOut),
        .y   (wdata)
    );

    // Enable gates the address compare so an X index cannot leak in.
    assign commit = wb.RegWriteOut && (wb.RegRdOut != ZERO);

    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (commit) begin
            regs_d[wb.RegRdOut] = wdata;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rd1 = regs_q[wb.ReadReg1];
        if (commit && (wb.ReadReg1 == wb.RegRdOut)) begin
            rd1 = wdata;
        end
        if (!Reset || (wb.ReadReg1 == ZERO)) begin
            rd1 = '0;
        end
    end

    always_comb begin
        rd2 = regs_q[wb.ReadReg2];
        if (commit && (wb.ReadReg2 == wb.RegRdOut)) begin
            rd2 = wdata;
        end
        if (!Reset || (wb.ReadReg2 == ZERO)) begin
            rd2 = '0;
        end
    end

    assign wb.ReadData1  = rd1;
    assign wb.ReadData2  = rd2;
    assign wb.WriteData  = wdata;
    assign wb.WriteCount = cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed-vector bench for writeback_regfile (32-bit and 4-bit counter builds).
module tb_writeback_regfile;

    logic Clk;
    logic Reset;

    int n_vec;
    int n_bad;

    writeback_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
    writeback_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

    writeback_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .wb    (bus.slave)
    );

    writeback_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
        .Clk   (Clk),
        .Reset (Reset),
        .wb    (bus4.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] rd,
                         input logic m2r, input logic [31:0] alu,
                         input logic [31:0] mem);
        bus.RegWriteOut    = we;
        bus.RegRdOut       = rd;
        bus.MemToRegOut    = m2r;
        bus.ALUResultOut   = alu;
        bus.MemReadDataOut = mem;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        Reset = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        bus.ReadReg1 = 5'd1;
        bus.ReadReg2 = 5'd2;
        bus4.RegWriteOut    = 1'b0;
        bus4.RegRdOut       = 5'd0;
        bus4.MemToRegOut    = 1'b0;
        bus4.ALUResultOut   = 32'h0;
        bus4.MemReadDataOut = 32'h0;
        bus4.ReadReg1       = 5'd0;
        bus4.ReadReg2       = 5'd0;
        #1;
        chk("rst_rd1", bus.ReadData1, 32'h0);
        chk("rst_rd2", bus.ReadData2, 32'h0);
        chk("rst_cnt", bus.WriteCount, 32'h0);
        #2 Reset = 1'b1;
        step();

        // ALU result into r8
        drive(1'b1, 5'd8, 1'b0, 32'h0000_00AA, 32'hDEAD_BEEF);
        #1;
        chk("mux_alu", bus.WriteData, 32'h0000_00AA);
        step();
        // Load data into r9
        drive(1'b1, 5'd9, 1'b1, 32'h0000_00AA, 32'hDEAD_BEEF);
        bus.ReadReg1 = 5'd8;
        #1;
        chk("mux_mem", bus.WriteData, 32'hDEAD_BEEF);
        chk("r8_val", bus.ReadData1, 32'h0000_00AA);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        bus.ReadReg2 = 5'd9;
        #1;
        chk("r9_val", bus.ReadData2, 32'hDEAD_BEEF);
        chk("cnt_2", bus.WriteCount, 32'd2);

        // Same-cycle bypass on both ports
        drive(1'b1, 5'd12, 1'b0, 32'h1234_5678, 32'h0BAD_0BAD);
        bus.ReadReg1 = 5'd12;
        bus.ReadReg2 = 5'd12;
        #1;
        chk("byp_rd1", bus.ReadData1, 32'h1234_5678);
        chk("byp_rd2", bus.ReadData2, 32'h1234_5678);
        step();
        drive(1'b0, 5'd12, 1'b0, 32'h0, 32'h0);
        #1;
        chk("r12_rd1", bus.ReadData1, 32'h1234_5678);
        chk("r12_rd2", bus.ReadData2, 32'h1234_5678);
        chk("cnt_3", bus.WriteCount, 32'd3);

        // Zero register: dropped, never bypassed
        drive(1'b1, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        bus.ReadReg1 = 5'd0;
        #1;
        chk("r0_wd", bus.WriteData, 32'hFFFF_FFFF);
        chk("r0_nobyp", bus.ReadData1, 32'h0);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("r0_after", bus.ReadData1, 32'h0);
        chk("r0_cnt", bus.WriteCount, 32'd3);

        // r3 = 7, then a disabled write targeting r3
        drive(1'b1, 5'd3, 1'b0, 32'd7, 32'h0);
        step();
        drive(1'b0, 5'd3, 1'b0, 32'h99, 32'h0);
        bus.ReadReg1 = 5'd3;
        #1;
        chk("dis_nobyp", bus.ReadData1, 32'd7);
        step();
        chk("dis_keep", bus.ReadData1, 32'd7);
        chk("dis_cnt", bus.WriteCount, 32'd4);

        // Unknown destination with write disabled
        drive(1'b0, 5'bxxxxx, 1'b0, 32'hEEEE_EEEE, 32'hEEEE_EEEE);
        bus.ReadReg2 = 5'd8;
        step();
        chk("x_r3", bus.ReadData1, 32'd7);
        chk("x_r8", bus.ReadData2, 32'h0000_00AA);
        chk("x_cnt", bus.WriteCount, 32'd4);

        // Independent ports: one bypasses, the other reads the array
        drive(1'b1, 5'd5, 1'b1, 32'h0, 32'h0000_0055);
        bus.ReadReg1 = 5'd5;
        bus.ReadReg2 = 5'd8;
        #1;
        chk("ind_byp", bus.ReadData1, 32'h0000_0055);
        chk("ind_arr", bus.ReadData2, 32'h0000_00AA);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        chk("cnt_5", bus.WriteCount, 32'd5);

        // Mid-cycle async reset, with a write request held during it
        bus.ReadReg1 = 5'd8;
        bus.ReadReg2 = 5'd9;
        #2 Reset = 1'b0;
        drive(1'b1, 5'd10, 1'b0, 32'hCAFE_F00D, 32'h0);
        #1;
        chk("arst_rd1", bus.ReadData1, 32'h0);
        chk("arst_rd2", bus.ReadData2, 32'h0);
        chk("arst_cnt", bus.WriteCount, 32'h0);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        Reset = 1'b1;
        bus.ReadReg1 = 5'd5;
        bus.ReadReg2 = 5'd10;
        #1;
        chk("post_r5", bus.ReadData1, 32'h0);
        chk("post_r10", bus.ReadData2, 32'h0);
        chk("post_cnt", bus.WriteCount, 32'h0);
        step();
        bus.ReadReg1 = 5'd8;
        #1;
        chk("post_r8", bus.ReadData1, 32'h0);

        // 4-bit counter wraps after 16 commits
        for (int i = 0; i < 17; i++) begin
            bus4.RegWriteOut  = 1'b1;
            bus4.RegRdOut     = 5'(1 + (i % 31));
            bus4.ALUResultOut = 32'(i);
            step();
            if (i == 14) chk("wrap_15", 32'(bus4.WriteCount), 32'd15);
            if (i == 15) chk("wrap_0", 32'(bus4.WriteCount), 32'd0);
        end
        bus4.RegWriteOut = 1'b0;
        #1;
        chk("wrap_1", 32'(bus4.WriteCount), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
